// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC core front end
package npc_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_WAIT,
    IFU_HOLD,
    IFU_HALT
  } ifu_state_e;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: fetch and stall event counters, wrapping at 2^32
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch,
  input  logic        stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  // count instruction handshakes and memory-bound cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and instruction fetcher feeding the IDU.
// Define IFU_PERF_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] new_pc;
  logic        kill;
  logic        drain;

  assign new_pc         = redirect_pc & ~32'h3;
  assign imem_req_valid = (state == IFU_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == IFU_HOLD);

  // fetch FSM: one outstanding request; kill drops a response made stale
  // by a redirect, drain swallows the in-flight response before halting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IFU_IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= RESET_PC;
      kill    <= 1'b0;
      drain   <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: state <= halt ? IFU_HALT : IFU_REQ;
        IFU_REQ: begin
          if (halt) begin
            state <= imem_req_ready ? IFU_WAIT : IFU_HALT;
            drain <= imem_req_ready;
          end else begin
            if (redirect_valid) pc <= new_pc;
            if (imem_req_ready) begin
              state <= IFU_WAIT;
              kill  <= redirect_valid;
            end
          end
        end
        IFU_WAIT: begin
          if (halt || drain) begin
            drain <= 1'b1;
            if (imem_rsp_valid) begin
              state <= IFU_HALT;
              drain <= 1'b0;
              kill  <= 1'b0;
            end
          end else if (redirect_valid) begin
            pc   <= new_pc;
            kill <= !imem_rsp_valid;
            if (imem_rsp_valid) state <= IFU_REQ;
          end else if (imem_rsp_valid) begin
            kill  <= 1'b0;
            state <= kill ? IFU_REQ : IFU_HOLD;
            if (!kill) begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
            end
          end
        end
        IFU_HOLD: begin
          if (halt) begin
            state <= IFU_HALT;
          end else if (redirect_valid) begin
            pc    <= new_pc;
            state <= IFU_REQ;
          end else if (inst_ready) begin
            pc    <= pc + 32'd4;
            state <= IFU_REQ;
          end
        end
        default: state <= IFU_HALT;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  ifu_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (inst_valid && inst_ready),
    .stall     (state == IFU_REQ || state == IFU_WAIT),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
